// File: rtl/score_bcd_counter_pkg.sv
// Shared definitions for the BCD score counter: digit limits, FSM states and
// the all-nines score constant for the default four-digit configuration.
package score_bcd_counter_pkg;

    localparam int                 BCD_W       = 4;
    localparam logic [BCD_W-1:0]   BCD_MAX     = 4'd9;
    localparam int                 NDIGITS_DEF = 4;

    localparam logic [BCD_W*NDIGITS_DEF-1:0] SCORE_ALL_NINES = {NDIGITS_DEF{BCD_MAX}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

endpackage

// File: rtl/score_bcd_counter_bcd_digit_inc.sv
// One BCD digit incrementer: adds carry-in to a digit, wrapping 9 -> 0 with
// carry-out, so a chain of these forms a ripple-carry BCD +1.
module bcd_digit_inc
    import score_bcd_counter_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    input  logic             i_carry,
    output logic [BCD_W-1:0] o_digit,
    output logic             o_carry
);

    // Digit increment with decimal wrap.
    always_comb begin
        o_digit = i_digit;
        o_carry = 1'b0;
        if (i_carry) begin
            if (i_digit >= BCD_MAX) begin
                o_digit = 4'd0;
                o_carry = 1'b1;
            end else begin
                o_digit = i_digit + 4'd1;
            end
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/score_bcd_counter.sv
// Pinball score held as packed BCD, incremented one unit per clock while
// awarding points, with a frame-latched copy for the digit renderers.
module score_bcd_counter
    import score_bcd_counter_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int PTS_W   = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     clear,
    input  logic                     add_valid,
    input  logic [PTS_W-1:0]         add_points,
    output logic                     add_ready,
    input  logic                     frame_tick,
    output logic [BCD_W*NDIGITS-1:0] score_digits,
    output logic [BCD_W*NDIGITS-1:0] disp_digits,
    output logic                     busy,
    output logic                     sat
);

    localparam logic [BCD_W*NDIGITS-1:0] SCORE_ZERO = {(BCD_W*NDIGITS){1'b0}};
    localparam logic [PTS_W-1:0]         PTS_ZERO   = {PTS_W{1'b0}};
    localparam logic [PTS_W-1:0]         PTS_ONE    = {{(PTS_W-1){1'b0}}, 1'b1};

    state_t                     r_state;
    logic [BCD_W*NDIGITS-1:0]   r_score;
    logic [BCD_W*NDIGITS-1:0]   r_disp;
    logic [PTS_W-1:0]           r_pending;
    logic                       r_sat;

    state_t                     w_state_nxt;
    logic [BCD_W*NDIGITS-1:0]   w_score_nxt;
    logic [PTS_W-1:0]           w_pending_nxt;
    logic                       w_sat_nxt;
    logic                       w_ready;
    logic [BCD_W*NDIGITS-1:0]   w_score_inc;
    logic [NDIGITS:0]           w_carry;

    // A carry out of the top digit means the score is already all nines.
    assign w_carry[0] = (r_state == ST_COUNT);

    for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
        bcd_digit_inc u_inc (
            .i_digit (r_score[g*BCD_W +: BCD_W]),
            .i_carry (w_carry[g]),
            .o_digit (w_score_inc[g*BCD_W +: BCD_W]),
            .o_carry (w_carry[g+1])
        );
    end

    // Next-state, score, pending and handshake logic; clear overrides all.
    always_comb begin
        w_state_nxt   = r_state;
        w_score_nxt   = r_score;
        w_pending_nxt = r_pending;
        w_sat_nxt     = r_sat;
        w_ready       = 1'b0;
        if (clear) begin
            w_state_nxt   = ST_IDLE;
            w_score_nxt   = SCORE_ZERO;
            w_pending_nxt = PTS_ZERO;
            w_sat_nxt     = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_ready = 1'b1;
                    if (add_valid && (add_points != PTS_ZERO)) begin
                        w_pending_nxt = add_points;
                        w_state_nxt   = ST_COUNT;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                    end
                end
                ST_COUNT: begin
                    if (w_carry[NDIGITS]) begin
                        w_pending_nxt = PTS_ZERO;
                        w_sat_nxt     = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end else begin
                        w_score_nxt   = w_score_inc;
                        w_pending_nxt = r_pending - PTS_ONE;
                        if (r_pending <= PTS_ONE) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_COUNT;
                        end
                    end
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_pending_nxt = PTS_ZERO;
                end
            endcase
        end
    end

    // State registers; the display copy samples the pre-edge score on frame_tick.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_score   <= SCORE_ZERO;
            r_disp    <= SCORE_ZERO;
            r_pending <= PTS_ZERO;
            r_sat     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_score   <= w_score_nxt;
            r_pending <= w_pending_nxt;
            r_sat     <= w_sat_nxt;
            if (frame_tick) begin
                r_disp <= r_score;
            end else begin
                r_disp <= r_disp;
            end
        end
    end

    assign add_ready    = w_ready;
    assign busy         = (r_state == ST_COUNT);
    assign sat          = r_sat;
    assign score_digits = r_score;
    assign disp_digits  = r_disp;

endmodule
